// File: rtl/isq_pkg.sv
// Shared constants, FSM state type and one-hot encoder for the issue-queue slot controller.
package isq_pkg;
   localparam int DEPTH = 8;
   localparam int LOG   = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // OR-reduction encoder; the result is meaningful only for a one-hot input.
   function automatic logic [LOG-1:0] oh2bin(input logic [DEPTH-1:0] oh);
      logic [LOG-1:0] b;
      b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (oh[i]) begin
            b = b | LOG'(i);
         end
      end
      return b;
   endfunction
endpackage

// File: rtl/isq_slot_ctrl_if.sv
// Dispatch, age-pick, FU issue and status signals of one issue-queue slot controller.
interface isq_slot_ctrl_if;
   import isq_pkg::*;

   logic             enq_valid;
   logic             enq_ready;
   logic [LOG-1:0]   enq_ptr;
   logic [DEPTH-1:0] iq_entries_wren_oh;
   logic             oldest_found;
   logic [DEPTH-1:0] oldest_idx_oh;
   logic             issue_valid;
   logic             issue_ready;
   logic             deq_fire;
   logic [LOG-1:0]   deq_ptr;
   logic [DEPTH-1:0] iq_entries_clear_entry;
   logic [DEPTH-1:0] iq_entries_valid;
   logic             flush;
   logic [LOG:0]     count;
   logic             full;
   logic             empty;

   modport master (
      output enq_valid, oldest_found, oldest_idx_oh, issue_ready, flush,
      input  enq_ready, enq_ptr, iq_entries_wren_oh, issue_valid, deq_fire, deq_ptr,
      input  iq_entries_clear_entry, iq_entries_valid, count, full, empty
   );

   modport slave (
      input  enq_valid, oldest_found, oldest_idx_oh, issue_ready, flush,
      output enq_ready, enq_ptr, iq_entries_wren_oh, issue_valid, deq_fire, deq_ptr,
      output iq_entries_clear_entry, iq_entries_valid, count, full, empty
   );
endinterface

// File: rtl/isq_free_pick.sv
// Lowest-index free-slot picker over the issue-queue valid vector.
module isq_free_pick
   import isq_pkg::*;
(
   input  logic [DEPTH-1:0] valid,
   output logic [LOG-1:0]   idx,
   output logic [DEPTH-1:0] oh,
   output logic             full
);
   logic found;

   always_comb begin
      oh    = '0;
      found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!valid[i] && !found) begin
            oh[i] = 1'b1;
            found = 1'b1;
         end
      end
   end

   assign idx  = oh2bin(oh);
   assign full = &valid;
endmodule

// File: rtl/isq_slot_ctrl.sv
// Issue-queue slot controller: valid vector, free-slot allocation, FU issue handshake and busy FSM.
// Defining ISQ_SLOT_STALL_CNT_EN adds the saturating stall_cycles counter output.
module isq_slot_ctrl
   import isq_pkg::*;
#(
   parameter int FU_BUSY_CYCLES = 0
) (
   input  logic clock,
   input  logic reset_n,
   isq_slot_ctrl_if.slave bus
`ifdef ISQ_SLOT_STALL_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);
   localparam int CNT_W = (FU_BUSY_CYCLES < 2) ? 1 : $clog2(FU_BUSY_CYCLES + 1);

   logic [DEPTH-1:0] valid_reg, valid_next;
   logic [LOG:0]     count_reg, count_next;
   state_t           state_reg, state_next;
   logic [CNT_W-1:0] busy_cnt_reg, busy_cnt_next;

   logic [LOG-1:0]   free_idx;
   logic [DEPTH-1:0] free_oh;
   logic             pick_full;
   logic             enq_ready, enq_fire, issue_valid, deq_fire;
   logic [DEPTH-1:0] wren_oh, clear_oh;

   isq_free_pick u_free_pick (
      .valid (valid_reg),
      .idx   (free_idx),
      .oh    (free_oh),
      .full  (pick_full)
   );

   // No enqueue bypass: a slot freed by this cycle's dequeue is reusable only next cycle.
   always_comb begin
      enq_ready   = !pick_full && !bus.flush;
      enq_fire    = bus.enq_valid && enq_ready;
      issue_valid = bus.oldest_found && (state_reg == IDLE) && !bus.flush;
      deq_fire    = issue_valid && bus.issue_ready;
      wren_oh     = enq_fire ? free_oh : '0;
      clear_oh    = deq_fire ? bus.oldest_idx_oh : '0;
   end

   always_comb begin
      valid_next    = (valid_reg | wren_oh) & ~clear_oh;
      count_next    = count_reg + (LOG+1)'(enq_fire) - (LOG+1)'(deq_fire);
      state_next    = state_reg;
      busy_cnt_next = busy_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (deq_fire && (FU_BUSY_CYCLES > 0)) begin
               state_next    = BUSY;
               busy_cnt_next = CNT_W'(FU_BUSY_CYCLES);
            end
         end
         BUSY: begin
            if (busy_cnt_reg <= CNT_W'(1)) begin
               state_next    = IDLE;
               busy_cnt_next = '0;
            end else begin
               busy_cnt_next = busy_cnt_reg - CNT_W'(1);
            end
         end
         default: begin
            state_next    = IDLE;
            busy_cnt_next = '0;
         end
      endcase
      if (bus.flush) begin
         valid_next    = '0;
         count_next    = '0;
         state_next    = IDLE;
         busy_cnt_next = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         valid_reg    <= '0;
         count_reg    <= '0;
         state_reg    <= IDLE;
         busy_cnt_reg <= '0;
      end else begin
         valid_reg    <= valid_next;
         count_reg    <= count_next;
         state_reg    <= state_next;
         busy_cnt_reg <= busy_cnt_next;
      end
   end

   assign bus.enq_ready              = enq_ready;
   assign bus.enq_ptr                = free_idx;
   assign bus.iq_entries_wren_oh     = wren_oh;
   assign bus.issue_valid            = issue_valid;
   assign bus.deq_fire               = deq_fire;
   assign bus.deq_ptr                = oh2bin(bus.oldest_idx_oh);
   assign bus.iq_entries_clear_entry = clear_oh;
   assign bus.iq_entries_valid       = valid_reg;
   assign bus.count                  = count_reg;
   assign bus.full                   = (count_reg == (LOG+1)'(DEPTH));
   assign bus.empty                  = (count_reg == '0);

`ifdef ISQ_SLOT_STALL_CNT_EN
   logic [31:0] stall_reg;
   logic        stall_hit;

   assign stall_hit = (bus.oldest_found && !issue_valid) || (issue_valid && !bus.issue_ready);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         stall_reg <= '0;
      end else if (stall_hit && (stall_reg != '1)) begin
         stall_reg <= stall_reg + 32'd1;
      end
   end

   assign stall_cycles = stall_reg;
`endif

   a_count_max: assert property (@(posedge clock) disable iff (!reset_n)
      count_reg <= (LOG+1)'(DEPTH));
   a_oldest_onehot: assert property (@(posedge clock) disable iff (!reset_n)
      bus.oldest_found |-> $onehot(bus.oldest_idx_oh));
   a_oldest_valid: assert property (@(posedge clock) disable iff (!reset_n)
      bus.oldest_found |-> |(bus.oldest_idx_oh & valid_reg));
endmodule

// File: tb/tb_isq_slot_ctrl.sv
// Scoreboard bench for isq_slot_ctrl: a pipelined DUT (FU_BUSY_CYCLES=0) and a blocking DUT (=2).
module tb_isq_slot_ctrl;
   import isq_pkg::*;

   localparam int FU1 = 2;

   typedef struct packed {
      logic             enq_ready;
      logic [LOG-1:0]   enq_ptr;
      logic [DEPTH-1:0] wren;
      logic             issue_valid;
      logic             deq_fire;
      logic [LOG-1:0]   deq_ptr;
      logic [DEPTH-1:0] clr;
      logic [DEPTH-1:0] valid;
      logic [LOG:0]     count;
      logic             full;
      logic             empty;
      logic [31:0]      stall;
   } obs_t;

   typedef struct {
      int   d;
      obs_t o;
   } exp_t;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic             s_ev[2];
   logic             s_of[2];
   logic             s_ir[2];
   logic             s_fl[2];
   logic [DEPTH-1:0] s_oh[2];

   isq_slot_ctrl_if bus0 ();
   isq_slot_ctrl_if bus1 ();
   logic [31:0] stall0, stall1;

   assign bus0.enq_valid     = s_ev[0];
   assign bus0.oldest_found  = s_of[0];
   assign bus0.oldest_idx_oh = s_oh[0];
   assign bus0.issue_ready   = s_ir[0];
   assign bus0.flush         = s_fl[0];
   assign bus1.enq_valid     = s_ev[1];
   assign bus1.oldest_found  = s_of[1];
   assign bus1.oldest_idx_oh = s_oh[1];
   assign bus1.issue_ready   = s_ir[1];
   assign bus1.flush         = s_fl[1];

`ifdef ISQ_SLOT_STALL_CNT_EN
   isq_slot_ctrl #(.FU_BUSY_CYCLES(0)) dut0 (.clock(clock), .reset_n(reset_n), .bus(bus0), .stall_cycles(stall0));
   isq_slot_ctrl #(.FU_BUSY_CYCLES(FU1)) dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1), .stall_cycles(stall1));
`else
   isq_slot_ctrl #(.FU_BUSY_CYCLES(0)) dut0 (.clock(clock), .reset_n(reset_n), .bus(bus0));
   isq_slot_ctrl #(.FU_BUSY_CYCLES(FU1)) dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1));
   assign stall0 = '0;
   assign stall1 = '0;
`endif

   obs_t act0, act1;
   assign act0 = {bus0.enq_ready, bus0.enq_ptr, bus0.iq_entries_wren_oh, bus0.issue_valid, bus0.deq_fire,
                  bus0.deq_ptr, bus0.iq_entries_clear_entry, bus0.iq_entries_valid, bus0.count,
                  bus0.full, bus0.empty, stall0};
   assign act1 = {bus1.enq_ready, bus1.enq_ptr, bus1.iq_entries_wren_oh, bus1.issue_valid, bus1.deq_fire,
                  bus1.deq_ptr, bus1.iq_entries_clear_entry, bus1.iq_entries_valid, bus1.count,
                  bus1.full, bus1.empty, stall1};

   // Reference model: set of occupied slots, remaining FU-blocked cycles, stall tally.
   bit          mval[2][DEPTH];
   int          mblock[2];
   int unsigned mstall[2];
   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;

   function automatic obs_t model_out(int d);
      obs_t o;
      int   n;
      int   fp;
      o  = '0;
      n  = 0;
      fp = -1;
      for (int i = 0; i < DEPTH; i++) begin
         if (mval[d][i]) n++;
         else if (fp < 0) fp = i;
         o.valid[i] = mval[d][i];
         if (s_oh[d][i]) o.deq_ptr = LOG'(i);
      end
      o.count       = (LOG+1)'(n);
      o.full        = (n == DEPTH);
      o.empty       = (n == 0);
      o.enq_ready   = !o.full && !s_fl[d];
      o.enq_ptr     = (fp < 0) ? '0 : LOG'(fp);
      if (s_ev[d] && o.enq_ready) o.wren[fp] = 1'b1;
      o.issue_valid = s_of[d] && (mblock[d] == 0) && !s_fl[d];
      o.deq_fire    = o.issue_valid && s_ir[d];
      if (o.deq_fire) o.clr = s_oh[d];
      o.stall       = mstall[d];
      return o;
   endfunction

   function automatic void model_step(int d, bit rst);
      obs_t o;
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mval[d][i] = 1'b0;
         mblock[d] = 0;
         mstall[d] = 0;
      end else begin
         o = model_out(d);
         if (((s_of[d] && !o.issue_valid) || (o.issue_valid && !s_ir[d])) && (mstall[d] != 32'hFFFF_FFFF))
            mstall[d]++;
         if (s_fl[d]) begin
            for (int i = 0; i < DEPTH; i++) mval[d][i] = 1'b0;
            mblock[d] = 0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (o.wren[i]) mval[d][i] = 1'b1;
               if (o.clr[i])  mval[d][i] = 1'b0;
            end
            if (mblock[d] > 0) mblock[d]--;
            else if (o.deq_fire) mblock[d] = (d == 0) ? 0 : FU1;
         end
      end
   endfunction

   task automatic set_in(input int d, input logic ev, input logic of, input logic [DEPTH-1:0] oh,
                         input logic ir, input logic fl);
      s_ev[d] = ev;
      s_of[d] = of;
      s_oh[d] = oh;
      s_ir[d] = ir;
      s_fl[d] = fl;
   endtask

   task automatic set_both(input logic ev, input logic of, input logic [DEPTH-1:0] oh,
                           input logic ir, input logic fl);
      set_in(0, ev, of, oh, ir, fl);
      set_in(1, ev, of, oh, ir, fl);
   endtask

   task automatic rand_in(input int d);
      int               idx[$];
      logic [DEPTH-1:0] oh;
      oh = '0;
      for (int i = 0; i < DEPTH; i++) if (mval[d][i]) idx.push_back(i);
      s_ev[d] = ($urandom_range(0, 3) != 0);
      s_of[d] = 1'b0;
      if (idx.size() > 0 && $urandom_range(0, 3) != 0) begin
         s_of[d] = 1'b1;
         oh[idx[$urandom_range(0, idx.size() - 1)]] = 1'b1;
      end
      s_oh[d] = oh;
      s_ir[d] = 1'($urandom_range(0, 1));
      s_fl[d] = ($urandom_range(0, 24) == 0);
   endtask

   // Inputs are applied just after a rising edge; expectations for that cycle go to the scoreboard.
   task automatic tick(input bit rst);
      exp_t e;
      reset_n = !rst;
      for (int d = 0; d < 2; d++) begin
         if (!rst) begin
            e.d = d;
            e.o = model_out(d);
            exp_q.push_back(e);
         end
         model_step(d, rst);
      end
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s dut%0d actual=%0h required=%0h", name, d, act, req);
      end
   endtask

   initial begin
      exp_t e;
      obs_t a;
      forever begin
         @(negedge clock);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = (e.d == 0) ? act0 : act1;
            $display("[%0t] dut%0d enq_rdy=%b ptr=%0d wren=%h iss=%b deq=%b dptr=%0d valid=%h cnt=%0d stall=%0d",
                     $time, e.d, a.enq_ready, a.enq_ptr, a.wren, a.issue_valid, a.deq_fire, a.deq_ptr,
                     a.valid, a.count, a.stall);
            chk("enq_ready", e.d, 32'(a.enq_ready), 32'(e.o.enq_ready));
            if (!e.o.full) chk("enq_ptr", e.d, 32'(a.enq_ptr), 32'(e.o.enq_ptr));
            chk("wren_oh", e.d, 32'(a.wren), 32'(e.o.wren));
            chk("issue_valid", e.d, 32'(a.issue_valid), 32'(e.o.issue_valid));
            chk("deq_fire", e.d, 32'(a.deq_fire), 32'(e.o.deq_fire));
            chk("deq_ptr", e.d, 32'(a.deq_ptr), 32'(e.o.deq_ptr));
            chk("clear_entry", e.d, 32'(a.clr), 32'(e.o.clr));
            chk("valid", e.d, 32'(a.valid), 32'(e.o.valid));
            chk("count", e.d, 32'(a.count), 32'(e.o.count));
            chk("full", e.d, 32'(a.full), 32'(e.o.full));
            chk("empty", e.d, 32'(a.empty), 32'(e.o.empty));
`ifdef ISQ_SLOT_STALL_CNT_EN
            chk("stall_cycles", e.d, a.stall, e.o.stall);
`endif
         end
      end
   end

   initial begin
      // Reset held for two edges while enqueue is offered; reset must win.
      set_both(1'b1, 1'b0, '0, 1'b0, 1'b0);
      tick(1);
      tick(1);
      // Fill all eight slots in order with the FU refusing.
      set_both(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 8; k++) tick(0);
      tick(0);
      // Full queue: dequeue slot 2 while enqueue is offered; the freed slot is refilled next cycle.
      set_both(1'b1, 1'b1, 8'h04, 1'b1, 1'b0);
      tick(0);
      set_both(1'b1, 1'b0, '0, 1'b0, 1'b0);
      tick(0);
      set_both(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick(0);
      tick(0);
      // Four entries, then same-cycle enqueue (slot 4) and dequeue (slot 1).
      set_both(1'b0, 1'b0, '0, 1'b0, 1'b1);
      tick(0);
      set_both(1'b1, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) tick(0);
      set_both(1'b1, 1'b1, 8'h02, 1'b1, 1'b0);
      tick(0);
      // Oldest entry offered while the blocking FU recovers from the previous issue.
      set_both(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) tick(0);
      set_both(1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
      tick(0);
      set_both(1'b0, 1'b0, '0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) tick(0);
      // Flush together with an enqueue and a ready oldest entry.
      set_both(1'b1, 1'b1, 8'h04, 1'b1, 1'b1);
      tick(0);
      set_both(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick(0);
      // Stall tally: five stalled cycles, then a flush that must not disturb it.
      tick(1);
      set_both(1'b1, 1'b0, '0, 1'b0, 1'b0);
      tick(0);
      set_both(1'b0, 1'b1, 8'h01, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) tick(0);
      set_both(1'b0, 1'b0, '0, 1'b0, 1'b1);
      tick(0);
      set_both(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick(0);
      tick(0);
      // Randomized traffic with an intermediate reset.
      for (int k = 0; k < 300; k++) begin
         rand_in(0);
         rand_in(1);
         tick(k == 150);
      end
      set_both(1'b0, 1'b0, '0, 1'b0, 1'b0);
      tick(0);
      @(negedge clock);
      #1;
      chk("scoreboard_drained", 0, 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
